wb_bram_port_bridge: RTL and testbench

Wishbone B4 pipelined slave that drives one port (A or B) of the wbTDPBRAM true-dual-port block RAM. It maps Wishbone reads and full-word writes straight onto the RAM port at one transaction per clock. Partial writes (i_wb_sel not all ones) become a two-cycle read-modify-write. One instance sits directly upstream of each RAM port that a bus master needs to reach.

---
 rtl/wb_bram_pkg.sv | 30 +++
 rtl/wb_bram_port_bridge_if.sv | 42 ++++
 rtl/wb_byte_merge.sv | 27 ++
 rtl/wb_bram_port_bridge.sv | 121 ++++++++++++
 tb/tb_wb_bram_port_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bram_pkg.sv
`default_nettype none
// ============================================================================
// Package    : wb_bram_pkg
// Purpose    : Shared types and helpers for the Wishbone-to-BRAM port bridge.
//              - state_e     : bridge FSM states (IDLE, MERGE)
//              - sel_width   : byte-select width derived from the data width
//              - byte_merge  : per-byte select between old and new data
// Revision   : 1.0 - initial release
// ============================================================================
package wb_bram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // One byte-select bit per 8-bit lane.
  function automatic int unsigned sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Byte lane merge: take the new byte where its select bit is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       sel);
    return sel ? new_b : old_b;
  endfunction

endpackage : wb_bram_pkg
`default_nettype wire

// File: rtl/wb_bram_port_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface  : wb_bram_port_bridge_if
// Purpose    : Wishbone B4 pipelined bus seen by the BRAM port bridge.
//              Signal names are from the bridge (slave) point of view.
// Ports      : i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel
//              (master -> slave); o_wb_stall, o_wb_ack, o_wb_data
//              (slave -> master).
// Modports   : master (bus initiator), slave (bridge).
// Revision   : 1.0 - initial release
// ============================================================================
interface wb_bram_port_bridge_if
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();

  localparam int SEL_WIDTH = sel_width(DATA_WIDTH);

  logic                  i_wb_cyc;
  logic                  i_wb_stb;
  logic                  i_wb_we;
  logic [ADDR_WIDTH-1:0] i_wb_addr;
  logic [DATA_WIDTH-1:0] i_wb_data;
  logic [SEL_WIDTH-1:0]  i_wb_sel;
  logic                  o_wb_stall;
  logic                  o_wb_ack;
  logic [DATA_WIDTH-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data
  );

endinterface : wb_bram_port_bridge_if
`default_nettype wire

// File: rtl/wb_byte_merge.sv
`default_nettype none
// ============================================================================
// Module     : wb_byte_merge
// Purpose    : Combinational byte-lane merge for read-modify-write.
// Ports      : old_i   - word currently stored in RAM
//              new_i   - partial write data
//              sel_i   - byte enables (bit k covers bits 8k+7:8k)
//              merged_o- new_i bytes where selected, old_i bytes elsewhere
// Revision   : 1.0 - initial release
// ============================================================================
module wb_byte_merge
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  for (genvar k = 0; k < DATA_WIDTH / 8; k++) begin : g_byte
    assign merged_o[8*k +: 8] = byte_merge(old_i[8*k +: 8], new_i[8*k +: 8], sel_i[k]);
  end

endmodule : wb_byte_merge
`default_nettype wire

// File: rtl/wb_bram_port_bridge.sv
`default_nettype none
// ============================================================================
// Module     : wb_bram_port_bridge
// Purpose    : Wishbone B4 pipelined slave driving one port of a true-dual-
//              port block RAM. Reads and full-word writes go straight to the
//              RAM at one per clock; partial writes become a two-cycle
//              read-modify-write (stall for one cycle).
// Ports      : i_clk, i_reset      - clock, async active-high reset
//              wb (slave modport)  - Wishbone request/response
//              o_bram_en/we/addr/din, i_bram_dout - RAM port
// Revision   : 1.0 - initial release
// ============================================================================
module wb_bram_port_bridge
  import wb_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  wb_bram_port_bridge_if.slave   wb,
  output logic                   o_bram_en,
  output logic                   o_bram_we,
  output logic [ADDR_WIDTH-1:0]  o_bram_addr,
  output logic [DATA_WIDTH-1:0]  o_bram_din,
  input  logic [DATA_WIDTH-1:0]  i_bram_dout
);

  localparam int                   SEL_WIDTH = sel_width(DATA_WIDTH);
  localparam logic [SEL_WIDTH-1:0] SEL_ALL   = '1;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;

  logic                  stall;
  logic                  accept;
  logic                  sel_full;
  logic                  sel_none;
  logic [DATA_WIDTH-1:0] merged;

  // Stall is forced during reset so nothing is accepted while it is held.
  assign stall    = i_reset | (state_q != IDLE);
  assign accept   = wb.i_wb_cyc & wb.i_wb_stb & ~stall;
  assign sel_full = (wb.i_wb_sel == SEL_ALL);
  assign sel_none = (wb.i_wb_sel == '0);

  assign wb.o_wb_stall = stall;
  assign wb.o_wb_ack   = ack_q;
  // RAM output is already registered; pass it straight through.
  assign wb.o_wb_data  = i_bram_dout;

  // In MERGE, i_bram_dout holds the word read in the previous cycle.
  wb_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_i    (i_bram_dout),
    .new_i    (data_q),
    .sel_i    (sel_q),
    .merged_o (merged)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    o_bram_en   = 1'b0;
    o_bram_we   = 1'b0;
    o_bram_addr = wb.i_wb_addr;
    o_bram_din  = wb.i_wb_data;

    case (state_q)
      IDLE: begin
        // A write with no byte enables is acknowledged without touching RAM.
        o_bram_en = accept & ~(wb.i_wb_we & sel_none);
        o_bram_we = accept & wb.i_wb_we & sel_full;
        ack_d     = accept;
        if (accept & wb.i_wb_we & ~sel_full & ~sel_none) begin
          // Partial write: this cycle is the read phase; ack after merge.
          state_d = MERGE;
          ack_d   = 1'b0;
          addr_d  = wb.i_wb_addr;
          data_d  = wb.i_wb_data;
          sel_d   = wb.i_wb_sel;
        end
      end
      MERGE: begin
        // Dropping CYC here abandons the write and its ack.
        o_bram_en   = wb.i_wb_cyc & ~i_reset;
        o_bram_we   = wb.i_wb_cyc & ~i_reset;
        o_bram_addr = addr_q;
        o_bram_din  = merged;
        ack_d       = wb.i_wb_cyc;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule : wb_bram_port_bridge
`default_nettype wire

// File: tb/tb_wb_bram_port_bridge.sv
`default_nettype none
// ============================================================================
// Module     : tb_wb_bram_port_bridge
// Purpose    : Directed self-checking bench for wb_bram_port_bridge with a
//              behavioural single-port RAM model (registered read output).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_wb_bram_port_bridge;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  wb_bram_port_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wbif ();

  wb_bram_port_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .wb          (wbif.slave),
    .o_bram_en   (bram_en),
    .o_bram_we   (bram_we),
    .o_bram_addr (bram_addr),
    .o_bram_din  (bram_din),
    .i_bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  // RAM port model: write when enabled+we, otherwise registered read.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] sl);
    wbif.i_wb_cyc  = c;
    wbif.i_wb_stb  = s;
    wbif.i_wb_we   = w;
    wbif.i_wb_addr = a;
    wbif.i_wb_data = d;
    wbif.i_wb_sel  = sl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[10'h002] = 32'h11223344;
    mem[10'h003] = 32'hCAFEF00D;
    mem[10'h004] = 32'hAAAAAAAA;
    mem[10'h005] = 32'h12345678;
    for (int i = 0; i < 8; i++) mem[10'h010 + i] = 32'h5A000010 + i;

    // Reset: request driven but must be ignored.
    drive(1'b1, 1'b1, 1'b1, 10'h001, 32'hFFFFFFFF, 4'hF);
    #2;
    chk("rst_stall", wbif.o_wb_stall, 1);
    chk("rst_en",    bram_en, 0);
    chk("rst_we",    bram_we, 0);
    chk("rst_ack",   wbif.o_wb_ack, 0);
    tick(); tick();
    idle();
    rst = 1'b0;
    tick();

    // 1. Full-word write then read.
    drive(1'b1, 1'b1, 1'b1, 10'h001, 32'hDEADBEEF, 4'hF);
    #1;
    chk("t1_wr_stall", wbif.o_wb_stall, 0);
    chk("t1_wr_en",    bram_en, 1);
    chk("t1_wr_we",    bram_we, 1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 10'h001, 32'h0, 4'hF);
    #1;
    chk("t1_wr_ack",   wbif.o_wb_ack, 1);
    chk("t1_rd_stall", wbif.o_wb_stall, 0);
    tick();
    idle();
    #1;
    chk("t1_rd_ack",  wbif.o_wb_ack, 1);
    chk("t1_rd_data", wbif.o_wb_data, 32'hDEADBEEF);
    tick();
    chk("t1_ack_off", wbif.o_wb_ack, 0);

    // 2. Partial write (byte 1) as read-modify-write.
    drive(1'b1, 1'b1, 1'b1, 10'h002, 32'h0000AB00, 4'b0010);
    #1;
    chk("t2_rd_en",  bram_en, 1);
    chk("t2_rd_we",  bram_we, 0);
    tick();
    #1;
    chk("t2_stall",  wbif.o_wb_stall, 1);
    chk("t2_m_en",   bram_en, 1);
    chk("t2_m_we",   bram_we, 1);
    chk("t2_m_addr", bram_addr, 10'h002);
    chk("t2_m_din",  bram_din, 32'h1122AB44);
    chk("t2_m_ack",  wbif.o_wb_ack, 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 10'h002, 32'h0, 4'hF);
    #1;
    chk("t2_ack",     wbif.o_wb_ack, 1);
    chk("t2_unstall", wbif.o_wb_stall, 0);
    tick();
    idle();
    #1;
    chk("t2_rd_ack",  wbif.o_wb_ack, 1);
    chk("t2_rd_data", wbif.o_wb_data, 32'h1122AB44);
    tick();

    // 3. Eight back-to-back reads.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 1'b1, 1'b0, 10'h010 + i, 32'h0, 4'hF);
      else       idle();
      #1;
      chk("t3_stall", wbif.o_wb_stall, 0);
      if (i >= 1 && i <= 8) begin
        chk("t3_ack",  wbif.o_wb_ack, 1);
        chk("t3_data", wbif.o_wb_data, 32'h5A000010 + i - 1);
      end else if (i == 9) begin
        chk("t3_ack_off", wbif.o_wb_ack, 0);
      end
      tick();
    end

    // 4. Write with no byte enables.
    drive(1'b1, 1'b1, 1'b1, 10'h003, 32'hFFFFFFFF, 4'h0);
    #1;
    chk("t4_en",    bram_en, 0);
    chk("t4_stall", wbif.o_wb_stall, 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 10'h003, 32'h0, 4'hF);
    #1;
    chk("t4_ack",   wbif.o_wb_ack, 1);
    chk("t4_rd_en", bram_en, 1);
    tick();
    idle();
    #1;
    chk("t4_rd_ack",  wbif.o_wb_ack, 1);
    chk("t4_rd_data", wbif.o_wb_data, 32'hCAFEF00D);
    tick();

    // 5. Abort during MERGE.
    drive(1'b1, 1'b1, 1'b1, 10'h004, 32'h00000055, 4'b0001);
    tick();
    idle();
    #1;
    chk("t5_stall", wbif.o_wb_stall, 1);
    chk("t5_en",    bram_en, 0);
    chk("t5_we",    bram_we, 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 10'h004, 32'h0, 4'hF);
    #1;
    chk("t5_no_ack",  wbif.o_wb_ack, 0);
    chk("t5_unstall", wbif.o_wb_stall, 0);
    tick();
    idle();
    #1;
    chk("t5_rd_ack",  wbif.o_wb_ack, 1);
    chk("t5_rd_data", wbif.o_wb_data, 32'hAAAAAAAA);
    tick();

    // 6. Reset during MERGE.
    drive(1'b1, 1'b1, 1'b1, 10'h005, 32'h000000FF, 4'b0001);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_ack",   wbif.o_wb_ack, 0);
    chk("t6_stall", wbif.o_wb_stall, 1);
    chk("t6_en",    bram_en, 0);
    chk("t6_we",    bram_we, 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 4'hF);
    #1;
    chk("t6_rel_stall", wbif.o_wb_stall, 0);
    chk("t6_rel_en",    bram_en, 1);
    chk("t6_rel_we",    bram_we, 0);
    tick();
    idle();
    #1;
    chk("t6_rd_ack",  wbif.o_wb_ack, 1);
    chk("t6_rd_data", wbif.o_wb_data, 32'h12345678);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_bram_port_bridge
`default_nettype wire
